// File: rtl/spatz_pkg.sv
// Shared Spatz types for the retire path: unit completion records, tracker
// entries and the X-interface result record.
package spatz_pkg;

    localparam int unsigned NrParallelInstructions = 4;
    localparam int unsigned ELEN = 32;

    typedef logic [$clog2(NrParallelInstructions)-1:0] spatz_id_t;
    typedef logic [ELEN-1:0] elen_t;
    typedef logic [4:0]      xintf_id_t;
    typedef logic [4:0]      reg_idx_t;

    typedef enum logic [1:0] {CON, VFU, LSU, SLD} ex_unit_e;

    typedef struct packed {
        spatz_id_t id;
        elen_t     result;
        reg_idx_t  rd;
        logic      wb;
    } vfu_rsp_t;

    typedef struct packed {
        spatz_id_t id;
        logic      exc;
    } vlsu_rsp_t;

    typedef struct packed {
        spatz_id_t id;
    } vsldu_rsp_t;

    typedef struct packed {
        xintf_id_t id;
        elen_t     data;
        reg_idx_t  rd;
        logic      we;
        logic      exc;
    } xif_result_t;

    typedef struct packed {
        logic      valid;
        xintf_id_t xintf_id;
        reg_idx_t  rd;
        logic      use_rd;
    } retire_entry_t;

endpackage

// File: rtl/spatz_retire_fifo.sv
// Generic synchronous-reset FIFO; the head entry is registered and reads as
// zero while the FIFO is empty.
module spatz_retire_fifo #(
    parameter int unsigned Depth = 2,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    T                mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] cnt_q;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/spatz_retire_unit.sv
// Tracks in-flight vector instructions from ID allocation to retirement and
// returns one result record per instruction on the X-interface result port.
module spatz_retire_unit
    import spatz_pkg::*;
#(
    parameter int unsigned NrParallelInstructions = spatz_pkg::NrParallelInstructions,
    parameter int unsigned RspFifoDepth           = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       issue_valid_i,
    output logic       issue_ready_o,
    output spatz_id_t  issue_id_o,
    input  logic [4:0] issue_xintf_id_i,
    input  logic [4:0] issue_rd_i,
    input  logic       issue_use_rd_i,
    input  logic       vfu_rsp_valid_i,
    output logic       vfu_rsp_ready_o,
    input  vfu_rsp_t   vfu_rsp_i,
    input  logic       vlsu_rsp_valid_i,
    output logic       vlsu_rsp_ready_o,
    input  vlsu_rsp_t  vlsu_rsp_i,
    input  logic       vsldu_rsp_valid_i,
    output logic       vsldu_rsp_ready_o,
    input  vsldu_rsp_t vsldu_rsp_i,
    output logic        xif_result_valid_o,
    input  logic        xif_result_ready_i,
    output logic [4:0]  xif_result_id_o,
    output logic [31:0] xif_result_data_o,
    output logic [4:0]  xif_result_rd_o,
    output logic        xif_result_we_o,
    output logic        xif_result_exc_o,
    output logic        busy_o
);

    retire_entry_t ent_q [NrParallelInstructions];
    retire_entry_t ent_d [NrParallelInstructions];

    logic        any_free, any_valid, issue_fire;
    spatz_id_t   free_id;
    logic        fifo_full, fifo_empty, fifo_push, fifo_pop, can_push;
    xif_result_t push_rec, head;
    logic        win_valid, grant, comp_hit, comp_wb, comp_exc;
    ex_unit_e    win_unit;
    spatz_id_t   comp_id;
    elen_t       comp_data;
    logic        unused_vfu_rd;

    // The unit's own rd is redundant: the tracker holds rd from issue time.
    assign unused_vfu_rd = ^vfu_rsp_i.rd;

    always_comb begin
        any_free  = 1'b0;
        any_valid = 1'b0;
        free_id   = '0;
        for (int i = int'(NrParallelInstructions) - 1; i >= 0; i--) begin
            if (ent_q[i].valid) begin
                any_valid = 1'b1;
            end else begin
                any_free = 1'b1;
                free_id  = spatz_id_t'(i);
            end
        end
    end

    assign issue_ready_o = rst_ni && any_free;
    assign issue_id_o    = free_id;
    assign issue_fire    = issue_valid_i && issue_ready_o;

    assign xif_result_valid_o = rst_ni && !fifo_empty;
    assign fifo_pop           = xif_result_valid_o && xif_result_ready_i;
    assign can_push           = !fifo_full || fifo_pop;

    always_comb begin
        win_valid = 1'b1;
        if (vfu_rsp_valid_i)        win_unit = VFU;
        else if (vlsu_rsp_valid_i)  win_unit = LSU;
        else if (vsldu_rsp_valid_i) win_unit = SLD;
        else begin
            win_unit  = CON;
            win_valid = 1'b0;
        end
    end

    assign grant             = rst_ni && can_push && win_valid;
    assign vfu_rsp_ready_o   = grant && (win_unit == VFU);
    assign vlsu_rsp_ready_o  = grant && (win_unit == LSU);
    assign vsldu_rsp_ready_o = grant && (win_unit == SLD);

    always_comb begin
        comp_id   = '0;
        comp_data = '0;
        comp_wb   = 1'b0;
        comp_exc  = 1'b0;
        case (win_unit)
            VFU: begin
                comp_id   = vfu_rsp_i.id;
                comp_data = vfu_rsp_i.result;
                comp_wb   = vfu_rsp_i.wb;
            end
            LSU: begin
                comp_id  = vlsu_rsp_i.id;
                comp_exc = vlsu_rsp_i.exc;
            end
            SLD:     comp_id = vsldu_rsp_i.id;
            default: ;
        endcase
    end

    // Completions for idle entries are consumed but never produce a record.
    assign comp_hit  = ent_q[comp_id].valid;
    assign fifo_push = grant && comp_hit;
    assign push_rec  = '{id:   ent_q[comp_id].xintf_id,
                         data: comp_data,
                         rd:   ent_q[comp_id].rd,
                         we:   ent_q[comp_id].use_rd && comp_wb,
                         exc:  comp_exc};

    always_comb begin
        ent_d = ent_q;
        if (grant) ent_d[comp_id].valid = 1'b0;
        if (issue_fire) begin
            ent_d[free_id] = '{valid:    1'b1,
                               xintf_id: issue_xintf_id_i,
                               rd:       issue_rd_i,
                               use_rd:   issue_use_rd_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NrParallelInstructions); i++) ent_q[i] <= '0;
        end else begin
            ent_q <= ent_d;
        end
    end

    spatz_retire_fifo #(
        .Depth (RspFifoDepth),
        .T     (xif_result_t)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .data_i  (push_rec),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign xif_result_id_o   = head.id;
    assign xif_result_data_o = head.data;
    assign xif_result_rd_o   = head.rd;
    assign xif_result_we_o   = head.we;
    assign xif_result_exc_o  = head.exc;
    assign busy_o            = rst_ni && (any_valid || !fifo_empty);

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (grant) begin
            assert (comp_hit)
            else $warning("spatz_retire_unit: completion for idle id %0d dropped", comp_id);
        end
    end
`endif

endmodule

// File: tb/tb_spatz_retire_unit.sv
// Randomised bench for spatz_retire_unit with an in-bench tracker/queue model
// checked every cycle, plus directed scenarios pinned by literal values.
module tb_spatz_retire_unit;
    import spatz_pkg::*;

    localparam int RSP_DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    spatz_id_t   issue_id_o;
    logic [4:0]  issue_xintf_id_i = '0;
    logic [4:0]  issue_rd_i = '0;
    logic        issue_use_rd_i = 1'b0;
    logic        vfu_rsp_valid_i = 1'b0, vfu_rsp_ready_o;
    vfu_rsp_t    vfu_rsp_i = '0;
    logic        vlsu_rsp_valid_i = 1'b0, vlsu_rsp_ready_o;
    vlsu_rsp_t   vlsu_rsp_i = '0;
    logic        vsldu_rsp_valid_i = 1'b0, vsldu_rsp_ready_o;
    vsldu_rsp_t  vsldu_rsp_i = '0;
    logic        xif_result_valid_o;
    logic        xif_result_ready_i = 1'b0;
    logic [4:0]  xif_result_id_o;
    logic [31:0] xif_result_data_o;
    logic [4:0]  xif_result_rd_o;
    logic        xif_result_we_o, xif_result_exc_o, busy_o;

    always #5 clk = ~clk;

    spatz_retire_unit #(
        .NrParallelInstructions (4),
        .RspFifoDepth           (RSP_DEPTH)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_ni),
        .issue_valid_i      (issue_valid_i),
        .issue_ready_o      (issue_ready_o),
        .issue_id_o         (issue_id_o),
        .issue_xintf_id_i   (issue_xintf_id_i),
        .issue_rd_i         (issue_rd_i),
        .issue_use_rd_i     (issue_use_rd_i),
        .vfu_rsp_valid_i    (vfu_rsp_valid_i),
        .vfu_rsp_ready_o    (vfu_rsp_ready_o),
        .vfu_rsp_i          (vfu_rsp_i),
        .vlsu_rsp_valid_i   (vlsu_rsp_valid_i),
        .vlsu_rsp_ready_o   (vlsu_rsp_ready_o),
        .vlsu_rsp_i         (vlsu_rsp_i),
        .vsldu_rsp_valid_i  (vsldu_rsp_valid_i),
        .vsldu_rsp_ready_o  (vsldu_rsp_ready_o),
        .vsldu_rsp_i        (vsldu_rsp_i),
        .xif_result_valid_o (xif_result_valid_o),
        .xif_result_ready_i (xif_result_ready_i),
        .xif_result_id_o    (xif_result_id_o),
        .xif_result_data_o  (xif_result_data_o),
        .xif_result_rd_o    (xif_result_rd_o),
        .xif_result_we_o    (xif_result_we_o),
        .xif_result_exc_o   (xif_result_exc_o),
        .busy_o             (busy_o)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: which IDs are live and what they carry, plus the
    // records still owed to the core, oldest first.
    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
    } rec_t;

    rec_t       exp_q[$];
    bit         m_valid [4];
    logic [4:0] m_xid [4];
    logic [4:0] m_rd [4];
    bit         m_use [4];
    bit         acc_vfu, acc_vlsu, acc_vsldu;
    bit         tgt [4];

    always @(negedge clk) begin
        int   fid, cid;
        bit   exp_ir, pop, can_push, exp_vr, exp_lr, exp_sr, live;
        rec_t head;
        acc_vfu = 0; acc_vlsu = 0; acc_vsldu = 0;
        if (!rst_ni) begin
            chk("rst_issue_ready", issue_ready_o, 0);
            chk("rst_vfu_ready", vfu_rsp_ready_o, 0);
            chk("rst_vlsu_ready", vlsu_rsp_ready_o, 0);
            chk("rst_vsldu_ready", vsldu_rsp_ready_o, 0);
            chk("rst_xif_valid", xif_result_valid_o, 0);
            chk("rst_busy", busy_o, 0);
            exp_q.delete();
            for (int i = 0; i < 4; i++) m_valid[i] = 0;
        end else begin
            fid = -1;
            live = 0;
            for (int i = 3; i >= 0; i--) begin
                if (!m_valid[i]) fid = i;
                else live = 1;
            end
            exp_ir = (fid >= 0);
            chk("issue_ready", issue_ready_o, exp_ir);
            if (exp_ir) chk("issue_id", issue_id_o, fid);
            pop      = (exp_q.size() > 0) && xif_result_ready_i;
            can_push = (exp_q.size() < RSP_DEPTH) || pop;
            exp_vr = can_push && vfu_rsp_valid_i;
            exp_lr = can_push && !vfu_rsp_valid_i && vlsu_rsp_valid_i;
            exp_sr = can_push && !vfu_rsp_valid_i && !vlsu_rsp_valid_i && vsldu_rsp_valid_i;
            chk("vfu_ready", vfu_rsp_ready_o, exp_vr);
            chk("vlsu_ready", vlsu_rsp_ready_o, exp_lr);
            chk("vsldu_ready", vsldu_rsp_ready_o, exp_sr);
            head = '0;
            if (exp_q.size() > 0) head = exp_q[0];
            chk("xif_valid", xif_result_valid_o, exp_q.size() > 0);
            chk("xif_id", xif_result_id_o, head.id);
            chk("xif_data", xif_result_data_o, head.data);
            chk("xif_rd", xif_result_rd_o, head.rd);
            chk("xif_we", xif_result_we_o, head.we);
            chk("xif_exc", xif_result_exc_o, head.exc);
            chk("busy", busy_o, live || exp_q.size() > 0);

            if (pop) void'(exp_q.pop_front());
            if (exp_vr) begin
                acc_vfu = 1;
                cid = int'(vfu_rsp_i.id);
                if (m_valid[cid]) begin
                    exp_q.push_back('{m_xid[cid], vfu_rsp_i.result, m_rd[cid],
                                      m_use[cid] && vfu_rsp_i.wb, 1'b0});
                    m_valid[cid] = 0;
                end
            end
            if (exp_lr) begin
                acc_vlsu = 1;
                cid = int'(vlsu_rsp_i.id);
                if (m_valid[cid]) begin
                    exp_q.push_back('{m_xid[cid], 32'h0, m_rd[cid], 1'b0, vlsu_rsp_i.exc});
                    m_valid[cid] = 0;
                end
            end
            if (exp_sr) begin
                acc_vsldu = 1;
                cid = int'(vsldu_rsp_i.id);
                if (m_valid[cid]) begin
                    exp_q.push_back('{m_xid[cid], 32'h0, m_rd[cid], 1'b0, 1'b0});
                    m_valid[cid] = 0;
                end
            end
            if (exp_ir && issue_valid_i) begin
                m_valid[fid] = 1;
                m_xid[fid]   = issue_xintf_id_i;
                m_rd[fid]    = issue_rd_i;
                m_use[fid]   = issue_use_rd_i;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (acc_vfu)   begin vfu_rsp_valid_i = 0;   tgt[vfu_rsp_i.id] = 0;   end
        if (acc_vlsu)  begin vlsu_rsp_valid_i = 0;  tgt[vlsu_rsp_i.id] = 0;  end
        if (acc_vsldu) begin vsldu_rsp_valid_i = 0; tgt[vsldu_rsp_i.id] = 0; end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_issue(input logic [4:0] xid, input logic [4:0] rd, input logic use_rd);
        issue_valid_i    = 1;
        issue_xintf_id_i = xid;
        issue_rd_i       = rd;
        issue_use_rd_i   = use_rd;
    endtask

    task automatic pick(output bit ok, output spatz_id_t id);
        int cand[$];
        for (int i = 0; i < 4; i++) if (m_valid[i] && !tgt[i]) cand.push_back(i);
        ok = cand.size() > 0;
        id = '0;
        if (ok) begin
            id = spatz_id_t'(cand[$urandom_range(cand.size() - 1)]);
            tgt[id] = 1;
        end
    endtask

    logic [4:0] xids [4] = '{5'd3, 5'd7, 5'd9, 5'd12};

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit        ok, done;
        spatz_id_t id;

        for (int i = 0; i < 4; i++) tgt[i] = 0;
        tick(); tick();
        rst_ni = 1;
        settle();
        chk("post_rst_issue_ready", issue_ready_o, 1);
        chk("post_rst_issue_id", issue_id_o, 0);
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_xif_valid", xif_result_valid_o, 0);

        for (int i = 0; i < 4; i++) begin
            set_issue(xids[i], 5'(4 + i), 1'b1);
            settle();
            chk("alloc_id", issue_id_o, i);
            tick();
        end
        issue_valid_i = 0;
        settle();
        chk("full_issue_ready", issue_ready_o, 0);

        xif_result_ready_i = 1;
        vfu_rsp_valid_i = 1;
        vfu_rsp_i = '{id: 2'd1, result: 32'hDEADBEEF, rd: 5'd0, wb: 1'b1};
        settle();
        chk("vfu_first_ready", vfu_rsp_ready_o, 1);
        tick();
        settle();
        chk("vfu_rec_valid", xif_result_valid_o, 1);
        chk("vfu_rec_id", xif_result_id_o, 7);
        chk("vfu_rec_rd", xif_result_rd_o, 5);
        chk("vfu_rec_data", xif_result_data_o, 32'hDEADBEEF);
        chk("vfu_rec_we", xif_result_we_o, 1);
        chk("vfu_rec_exc", xif_result_exc_o, 0);
        chk("realloc_id", issue_id_o, 1);
        set_issue(5'd20, 5'd6, 1'b1);
        tick();
        issue_valid_i = 0;

        vfu_rsp_valid_i = 1;   vfu_rsp_i = '{id: 2'd0, result: 32'h1234, rd: 5'd0, wb: 1'b0};
        vlsu_rsp_valid_i = 1;  vlsu_rsp_i = '{id: 2'd2, exc: 1'b1};
        vsldu_rsp_valid_i = 1; vsldu_rsp_i = '{id: 2'd3};
        tick(); settle();
        chk("prio1_id", xif_result_id_o, 3);
        chk("prio1_we", xif_result_we_o, 0);
        tick(); settle();
        chk("prio2_id", xif_result_id_o, 9);
        chk("prio2_exc", xif_result_exc_o, 1);
        chk("prio2_we", xif_result_we_o, 0);
        tick(); settle();
        chk("prio3_id", xif_result_id_o, 12);
        chk("prio3_exc", xif_result_exc_o, 0);
        tick();

        xif_result_ready_i = 0;
        for (int j = 0; j < 3; j++) begin
            set_issue(5'(j + 1), 5'(j + 1), 1'b0);
            tick();
        end
        issue_valid_i = 0;
        vfu_rsp_valid_i = 1;   vfu_rsp_i = '{id: 2'd0, result: 32'h5, rd: 5'd0, wb: 1'b1};
        vlsu_rsp_valid_i = 1;  vlsu_rsp_i = '{id: 2'd2, exc: 1'b0};
        vsldu_rsp_valid_i = 1; vsldu_rsp_i = '{id: 2'd3};
        tick(); tick(); settle();
        chk("bp_vsldu_ready", vsldu_rsp_ready_o, 0);
        chk("bp_head_id", xif_result_id_o, 1);
        tick(); settle();
        chk("bp_vsldu_ready_hold", vsldu_rsp_ready_o, 0);
        xif_result_ready_i = 1;
        settle();
        chk("pop_vsldu_ready", vsldu_rsp_ready_o, 1);
        tick(); tick(); tick();

        xif_result_ready_i = 0;
        for (int j = 0; j < 3; j++) begin
            set_issue(5'(21 + j), 5'(j), 1'b1);
            tick();
        end
        issue_valid_i = 0;
        vsldu_rsp_valid_i = 1; vsldu_rsp_i = '{id: 2'd1};
        tick(); settle();
        chk("pre_rst_busy", busy_o, 1);
        chk("pre_rst_xif_valid", xif_result_valid_o, 1);
        rst_ni = 0;
        tick();
        rst_ni = 1;
        settle();
        chk("mid_rst_xif_valid", xif_result_valid_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_issue_id", issue_id_o, 0);

        xif_result_ready_i = 1;
        set_issue(5'd30, 5'd1, 1'b1);
        tick();
        issue_valid_i = 0;
        vsldu_rsp_valid_i = 1; vsldu_rsp_i = '{id: 2'd2};
        settle();
        chk("idle_id_ready", vsldu_rsp_ready_o, 1);
        tick(); settle();
        chk("idle_id_no_rec", xif_result_valid_o, 0);
        chk("idle_id_busy", busy_o, 1);
        vfu_rsp_valid_i = 1; vfu_rsp_i = '{id: 2'd0, result: 32'h0, rd: 5'd0, wb: 1'b0};
        tick(); tick(); tick();

        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst_ni = 0;
                issue_valid_i = 0;
                vfu_rsp_valid_i = 0; vlsu_rsp_valid_i = 0; vsldu_rsp_valid_i = 0;
                for (int i = 0; i < 4; i++) tgt[i] = 0;
                tick();
                rst_ni = 1;
            end
            xif_result_ready_i = ($urandom_range(3) != 0);
            issue_valid_i      = 1'($urandom_range(1));
            issue_xintf_id_i   = 5'($urandom);
            issue_rd_i         = 5'($urandom);
            issue_use_rd_i     = 1'($urandom);
            if (!vfu_rsp_valid_i && $urandom_range(2) == 0) begin
                pick(ok, id);
                if (ok) begin
                    vfu_rsp_valid_i = 1;
                    vfu_rsp_i = '{id: id, result: 32'($urandom), rd: 5'($urandom), wb: 1'($urandom)};
                end
            end
            if (!vlsu_rsp_valid_i && $urandom_range(2) == 0) begin
                pick(ok, id);
                if (ok) begin
                    vlsu_rsp_valid_i = 1;
                    vlsu_rsp_i = '{id: id, exc: 1'($urandom)};
                end
            end
            if (!vsldu_rsp_valid_i && $urandom_range(2) == 0) begin
                pick(ok, id);
                if (ok) begin
                    vsldu_rsp_valid_i = 1;
                    vsldu_rsp_i = '{id: id};
                end
            end
            tick();
        end

        issue_valid_i = 0;
        xif_result_ready_i = 1;
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (!vsldu_rsp_valid_i) begin
                pick(ok, id);
                if (ok) begin
                    vsldu_rsp_valid_i = 1;
                    vsldu_rsp_i = '{id: id};
                end
            end
            tick();
            done = (exp_q.size() == 0) && !vfu_rsp_valid_i && !vlsu_rsp_valid_i &&
                   !vsldu_rsp_valid_i && !m_valid[0] && !m_valid[1] && !m_valid[2] && !m_valid[3];
        end
        chk("drain_done", done, 1);
        settle();
        chk("final_busy", busy_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spatz_retire_unit.md
Name: spatz_retire_unit

Overview:
- Completion end of the Spatz offload path: tracks in-flight vector instructions from issue to retirement.
- Allocates a spatz_id_t at issue, holding xintf_id and rd per entry.
- Accepts completions from VFU, VLSU and VSLDU, frees the ID, and sends one result record per instruction back to the core on the X-interface result channel.
- Sits between the Spatz controller/units and the core's offload result port.

Parameters:
- NrParallelInstructions, 4, tracker entries; equals spatz_pkg value, width of spatz_id_t.
- RspFifoDepth, 2, result FIFO entries (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- issue_valid_i  in  1  controller requests an ID
- issue_ready_o  out  1  a free ID exists
- issue_id_o  out  2  allocated spatz_id_t
- issue_xintf_id_i  in  5  core request id
- issue_rd_i  in  5  scalar destination
- issue_use_rd_i  in  1  instruction writes rd
- vfu_rsp_valid_i / vfu_rsp_ready_o  in/out  1  VFU completion handshake
- vfu_rsp_i  in  40  vfu_rsp_t {id, result, rd, wb}
- vlsu_rsp_valid_i / vlsu_rsp_ready_o  in/out  1  VLSU completion handshake
- vlsu_rsp_i  in  3  vlsu_rsp_t {id, exc}
- vsldu_rsp_valid_i / vsldu_rsp_ready_o  in/out  1  VSLDU completion handshake
- vsldu_rsp_i  in  2  vsldu_rsp_t {id}
- xif_result_valid_o  out  1  result record valid
- xif_result_ready_i  in  1  core accepts
- xif_result_id_o  out  5  xintf_id of retiring instruction
- xif_result_data_o  out  32  writeback data
- xif_result_rd_o  out  5  destination register
- xif_result_we_o  out  1  register write
- xif_result_exc_o  out  1  memory exception
- busy_o  out  1  any entry in flight or FIFO non-empty

Behaviour:
- Reset (sync, rst_ni=0 at posedge): all entries invalid, FIFO emptied. xif_result_valid_o=0, busy_o=0, all ready=0 during reset. issue_ready_o=1 from the first cycle after reset.
- Tracker entry fields: valid, xintf_id, rd, use_rd.
- Allocation:
  - issue_id_o = lowest-index invalid entry, computed from the start-of-cycle valid mask. issue_ready_o = any invalid entry.
  - On issue_valid_i && issue_ready_o the entry is written valid at the next edge.
  - An ID freed in cycle N is allocatable from cycle N+1 only.
- Completion arbitration, fixed priority VFU > VLSU > VSLDU:
  - At most one completion is accepted per cycle. Only the winner sees ready=1, and only when the FIFO can push (!full, or full and popping this cycle).
  - Losers hold valid and data stable.
- On an accepted completion with id k:
  - Entry k is cleared at the next edge.
  - Push record {xintf_id[k], rd[k], data, we, exc}.
  - VFU: data=result, we=use_rd[k] && wb.
  - VLSU: data=0, we=0, exc=exc.
  - VSLDU: data=0, we=0, exc=0.
- Completion for an invalid entry: accepted, dropped, no push. Flagged by an assertion.
- Result FIFO:
  - Registered: a record is visible on xif_result_* the cycle after acceptance, so completion-to-result latency is 1 cycle.
  - Pop on xif_result_valid_o && xif_result_ready_i.
  - Outputs stay stable while valid && !ready.
  - Outputs are zero when the FIFO is empty.
- Simultaneous issue and completion touch different entries; both proceed in the same cycle.
- Full tracker: issue_ready_o=0 until a completion is accepted.
- Full FIFO with no pop: all unit readies=0 (backpressure to units).
- Reset mid-operation discards all in-flight state; no results are emitted for discarded entries.

Decomposition:
- spatz_pkg gains:
  - xif_result_t {id[4:0], data elen_t, rd, we, exc}
  - retire_entry_t {valid, xintf_id, rd, use_rd}
  - ex_unit_e is reused to tag the arbitration winner.
- Sub-module spatz_retire_fifo: generic synchronous-reset FIFO, parameterised on depth and type, with full, empty, push and pop.

Test Plan:
- Reset, then issue 4 instrs (xintf_id 3,7,9,12) -> IDs 0,1,2,3; issue_ready_o=0 after the fourth.
- VFU rsp id=1, wb=1, result=0xDEADBEEF; entry use_rd=1, rd=5 -> next cycle xif_result {id=7, rd=5, data=0xDEADBEEF, we=1, exc=0}; ID 1 reallocated on the following issue.
- VFU, VLSU(id 2, exc=1) and VSLDU(id 3) valid in the same cycle -> accepted in order VFU, VLSU, VSLDU on consecutive cycles; VLSU record exc=1, we=0.
- xif_result_ready_i=0 with RspFifoDepth=2 -> two completions accepted, third unit sees ready=0 until a pop, then ready=1 in the pop cycle.
- Reset asserted with 3 entries valid and FIFO holding 1 record -> next cycle xif_result_valid_o=0, busy_o=0, issue_id_o=0.
- VSLDU completion for never-issued id 2 -> accepted, no result record, assertion fires, busy_o unchanged.
